// File: rtl/iter_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : iter_alu_if
// Description : Start/done request and result bundle for the iterative ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface iter_alu_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             div_zero;

    modport master (
        output start, op, a_in, b_in,
        input  ready, done, result, zero, overflow, div_zero
    );

    modport slave (
        input  start, op, a_in, b_in,
        output ready, done, result, zero, overflow, div_zero
    );
endinterface
`default_nettype wire

// File: rtl/iter_alu.sv
`default_nettype none
// ============================================================================
// Module      : iter_alu
// Description : Multi-cycle signed ALU: single-cycle add/sub/and/or, iterative
//               shift-add multiply and restoring divide/remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_alu #(
    parameter int WIDTH = 64
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    iter_alu_if.slave  bus
);
    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ITER = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    localparam logic [2:0] c_OP_ADD = 3'd1;
    localparam logic [2:0] c_OP_SUB = 3'd2;
    localparam logic [2:0] c_OP_MUL = 3'd3;
    localparam logic [2:0] c_OP_DIV = 3'd4;
    localparam logic [2:0] c_OP_AND = 3'd5;
    localparam logic [2:0] c_OP_OR  = 3'd6;
    localparam logic [2:0] c_OP_REM = 3'd7;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               w_ready;

    logic [2:0]         r_op;
    logic               r_neg_a;
    logic               r_neg_b;
    logic               r_min_m1;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_ovf;
    logic               r_dz;
    logic               r_done;

    logic               w_accept;
    logic               w_b_zero;
    logic               w_start_iter;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_sc_res;
    logic               w_sc_ovf;
    logic               w_sc_dz;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_top;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_next;

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo_mag;
    logic [WIDTH-1:0]   w_rem_mag;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_res;
    logic               w_fix_ovf;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_accept && w_start_iter) w_next_state = c_ITER;
            c_ITER:  if (r_cnt == c_LAST) w_next_state = c_FIX;
            c_FIX:   w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_ready = (r_state == c_IDLE);
    end

    // ------------------------------------------------ acceptance datapath
    assign w_accept     = bus.start && w_ready;
    assign w_b_zero     = (bus.b_in == '0);
    assign w_start_iter = (bus.op == c_OP_MUL) ||
                          (((bus.op == c_OP_DIV) || (bus.op == c_OP_REM)) && !w_b_zero);
    assign w_sum        = bus.a_in + bus.b_in;
    assign w_diff       = bus.a_in - bus.b_in;
    // Magnitude of MIN is 2^(WIDTH-1), still representable as unsigned.
    assign w_abs_a      = bus.a_in[WIDTH-1] ? (~bus.a_in + 1'b1) : bus.a_in;
    assign w_abs_b      = bus.b_in[WIDTH-1] ? (~bus.b_in + 1'b1) : bus.b_in;

    always_comb begin
        w_sc_res = '0;
        w_sc_ovf = 1'b0;
        w_sc_dz  = 1'b0;
        case (bus.op)
            c_OP_ADD: begin
                w_sc_res = w_sum;
                w_sc_ovf = (bus.a_in[WIDTH-1] == bus.b_in[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != bus.a_in[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_sc_res = w_diff;
                w_sc_ovf = (bus.a_in[WIDTH-1] != bus.b_in[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != bus.a_in[WIDTH-1]);
            end
            c_OP_AND: w_sc_res = bus.a_in & bus.b_in;
            c_OP_OR:  w_sc_res = bus.a_in | bus.b_in;
            c_OP_DIV: begin
                w_sc_res = '1;
                w_sc_dz  = 1'b1;
            end
            c_OP_REM: begin
                w_sc_res = bus.a_in;
                w_sc_dz  = 1'b1;
            end
            default: w_sc_res = '0;
        endcase
    end

    // ------------------------------------------------- iteration datapath
    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    assign w_mul_next  = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                  : {1'b0, r_acc[2*WIDTH-1:1]};
    // Remainder stays below the divisor, so the shifted value fits WIDTH+1 bits.
    assign w_div_top   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_trial = w_div_top - {1'b0, r_opnd};
    assign w_div_next  = w_div_trial[WIDTH]
                       ? {w_div_top[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    // ------------------------------------------------------- fix datapath
    assign w_prod    = (r_neg_a ^ r_neg_b) ? (~r_acc + 1'b1) : r_acc;
    assign w_quo_mag = r_acc[WIDTH-1:0];
    assign w_rem_mag = r_acc[2*WIDTH-1:WIDTH];
    assign w_quo     = (r_neg_a ^ r_neg_b) ? (~w_quo_mag + 1'b1) : w_quo_mag;
    assign w_rem     = r_neg_a ? (~w_rem_mag + 1'b1) : w_rem_mag;

    always_comb begin
        w_fix_res = '0;
        w_fix_ovf = 1'b0;
        case (r_op)
            c_OP_MUL: begin
                w_fix_res = w_prod[WIDTH-1:0];
                w_fix_ovf = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
            end
            c_OP_DIV: begin
                w_fix_res = w_quo;
                w_fix_ovf = r_min_m1;
            end
            c_OP_REM: begin
                w_fix_res = w_rem;
                w_fix_ovf = r_min_m1;
            end
            default: w_fix_res = '0;
        endcase
    end

    // --------------------------------------------------- register update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_min_m1 <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_dz     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_op <= bus.op;
                        if (w_start_iter) begin
                            r_neg_a  <= bus.a_in[WIDTH-1];
                            r_neg_b  <= bus.b_in[WIDTH-1];
                            r_min_m1 <= (bus.a_in == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                        (bus.b_in == '1);
                            r_cnt    <= '0;
                            if (bus.op == c_OP_MUL) begin
                                r_opnd <= w_abs_a;
                                r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                            end else begin
                                r_opnd <= w_abs_b;
                                r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                            end
                        end else begin
                            r_result <= w_sc_res;
                            r_zero   <= (w_sc_res == '0);
                            r_ovf    <= w_sc_ovf;
                            r_dz     <= w_sc_dz;
                            r_done   <= 1'b1;
                        end
                    end
                end
                c_ITER: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_acc <= (r_op == c_OP_MUL) ? w_mul_next : w_div_next;
                end
                c_FIX: begin
                    r_result <= w_fix_res;
                    r_zero   <= (w_fix_res == '0);
                    r_ovf    <= w_fix_ovf;
                    r_dz     <= 1'b0;
                    r_done   <= 1'b1;
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign bus.ready    = w_ready;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.zero     = r_zero;
    assign bus.overflow = r_ovf;
    assign bus.div_zero = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_iter_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_alu
// Description : Directed-vector bench for iter_alu at WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_alu;
    localparam int c_W        = 8;
    localparam int c_LAT_ITER = c_W + 1;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    iter_alu_if #(.WIDTH(c_W)) bus ();

    iter_alu #(.WIDTH(c_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op and count edges after the accepting edge until done shows.
    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a_in  = 8'($urandom);
        bus.b_in  = 8'($urandom);
        bus.op    = 3'($urandom);
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.done) lat = -1;
    endtask

    task automatic do_vec(input string tag, input logic [2:0] o, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] e_res, input logic e_zero,
                          input logic e_ovf, input logic e_dz, input int e_lat);
        int lat;
        run_op(o, a, b, lat);
        check_val({tag, ".lat"}, 64'(lat), 64'(e_lat));
        check_val({tag, ".res"}, 64'(bus.result), 64'(e_res));
        check_val({tag, ".zero"}, 64'(bus.zero), 64'(e_zero));
        check_val({tag, ".ovf"}, 64'(bus.overflow), 64'(e_ovf));
        check_val({tag, ".dz"}, 64'(bus.div_zero), 64'(e_dz));
        check_val({tag, ".rdy"}, 64'(bus.ready), 64'd1);
        @(posedge clk);
        #1;
        check_val({tag, ".pulse"}, 64'(bus.done), 64'd0);
        check_val({tag, ".hold"}, 64'(bus.result), 64'(e_res));
    endtask

    initial begin
        logic [7:0] bb_a [3];
        logic [7:0] bb_b [3];
        logic [7:0] bb_r [3];
        int         n_done;
        int         first_e;
        logic [7:0] first_res;
        int         lat;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a_in  = 8'd0;
        bus.b_in  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.ready", 64'(bus.ready), 64'd1);
        check_val("rst.done", 64'(bus.done), 64'd0);
        check_val("rst.result", 64'(bus.result), 64'd0);
        check_val("rst.zero", 64'(bus.zero), 64'd1);
        check_val("rst.ovf", 64'(bus.overflow), 64'd0);
        check_val("rst.dz", 64'(bus.div_zero), 64'd0);
        rst_n = 1'b1;

        //       tag        op    a      b      res    z     ov    dz    lat
        do_vec("add_ovf",  3'd1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 0);
        do_vec("sub_zero", 3'd2, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 0);
        do_vec("sub_ovf",  3'd2, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 0);
        do_vec("and",      3'd5, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 0);
        do_vec("or",       3'd6, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b0, 0);
        do_vec("illegal",  3'd0, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b0, 0);
        do_vec("mul_neg",  3'd3, 8'hFD, 8'h07, 8'hEB, 1'b0, 1'b0, 1'b0, c_LAT_ITER);
        do_vec("mul_ovf",  3'd3, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0, c_LAT_ITER);
        do_vec("mul_m1m1", 3'd3, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, c_LAT_ITER);
        do_vec("mul_minm1",3'd3, 8'h80, 8'hFF, 8'h80, 1'b0, 1'b1, 1'b0, c_LAT_ITER);
        do_vec("div_neg",  3'd4, 8'hF9, 8'h02, 8'hFD, 1'b0, 1'b0, 1'b0, c_LAT_ITER);
        do_vec("rem_neg",  3'd7, 8'hF9, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0, c_LAT_ITER);
        do_vec("div_negb", 3'd4, 8'h07, 8'hFE, 8'hFD, 1'b0, 1'b0, 1'b0, c_LAT_ITER);
        do_vec("rem_negb", 3'd7, 8'h07, 8'hFE, 8'h01, 1'b0, 1'b0, 1'b0, c_LAT_ITER);
        do_vec("div_minm1",3'd4, 8'h80, 8'hFF, 8'h80, 1'b0, 1'b1, 1'b0, c_LAT_ITER);
        do_vec("rem_minm1",3'd7, 8'h80, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, c_LAT_ITER);
        do_vec("div_by0",  3'd4, 8'h05, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 0);
        do_vec("rem_by0",  3'd7, 8'h05, 8'h00, 8'h05, 1'b0, 1'b0, 1'b1, 0);
        do_vec("dz_clear", 3'd1, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 0);

        // Back-to-back single-cycle adds, one done per cycle.
        bb_a = '{8'h01, 8'h10, 8'hF0};
        bb_b = '{8'h02, 8'h20, 8'h10};
        bb_r = '{8'h03, 8'h30, 8'h00};
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.start = 1'b1;
            bus.op    = 3'd1;
            bus.a_in  = bb_a[i];
            bus.b_in  = bb_b[i];
            @(posedge clk);
            #1;
            check_val($sformatf("b2b%0d.done", i), 64'(bus.done), 64'd1);
            check_val($sformatf("b2b%0d.res", i), 64'(bus.result), 64'(bb_r[i]));
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check_val("b2b.end", 64'(bus.done), 64'd0);

        // Add requested while a divide iterates must be dropped.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.a_in  = 8'd64;
        bus.b_in  = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_val("busy.ready", 64'(bus.ready), 64'd0);
        n_done    = 0;
        first_e   = -1;
        first_res = 8'h00;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                n_done++;
                if (first_e < 0) begin
                    first_e   = e;
                    first_res = bus.result;
                end
            end
            if (e == 2) begin
                bus.start = 1'b1;
                bus.op    = 3'd1;
                bus.a_in  = 8'd1;
                bus.b_in  = 8'd1;
            end else begin
                bus.start = 1'b0;
            end
        end
        check_val("busy.ndone", 64'(n_done), 64'd1);
        check_val("busy.lat", 64'(first_e), 64'(c_LAT_ITER));
        check_val("busy.res", 64'(first_res), 64'h09);
        check_val("busy.hold", 64'(bus.result), 64'h09);

        // Reset in the middle of a multiply aborts it without a done.
        run_op(3'd3, 8'h05, 8'h05, lat);
        check_val("pre.res", 64'(bus.result), 64'h19);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd3;
        bus.a_in  = 8'h03;
        bus.b_in  = 8'h03;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("mrst.ready", 64'(bus.ready), 64'd1);
        check_val("mrst.done", 64'(bus.done), 64'd0);
        check_val("mrst.result", 64'(bus.result), 64'd0);
        check_val("mrst.zero", 64'(bus.zero), 64'd1);
        n_done = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
        end
        check_val("mrst.nodone", 64'(n_done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
